// File: rtl/tt_uart_pkg.sv
// tt_uart_pkg
//   Shared definitions for the uio UART transmit path.
//   tx_state_t       : transmitter FSM states (IDLE, START, DATA, STOP)
//   UART_DATA_BITS   : payload bits per frame
//   UART_FRAME_BITS  : start + payload + stop bits per frame
package tt_uart_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        DATA  = 2'd2,
        STOP  = 2'd3
    } tx_state_t;

    localparam int UART_DATA_BITS  = 8;
    localparam int UART_FRAME_BITS = 10;

endpackage

// File: rtl/tt_sync_fifo.sv
// tt_sync_fifo
//   Small synchronous first-word-fall-through FIFO. rdata always shows the
//   oldest stored word while empty is low.
//   Ports:
//     clk    in   system clock
//     rst_n  in   asynchronous active-low reset (clears pointers and count)
//     push   in   write wdata this edge (ignored when full)
//     wdata  in   WIDTH-bit write data
//     pop    in   discard the head word this edge (ignored when empty)
//     rdata  out  head word
//     full   out  DEPTH words stored
//     empty  out  no words stored
module tt_sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push,
    input  logic [WIDTH-1:0] wdata,
    input  logic             pop,
    output logic [WIDTH-1:0] rdata,
    output logic             full,
    output logic             empty
);

    localparam int AW   = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CNTW = AW + 1;
    localparam logic [CNTW-1:0] DEPTH_C = CNTW'(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic [CNTW-1:0]  count;
    logic             do_push;
    logic             do_pop;

    assign do_push = push && !full;
    assign do_pop  = pop && !empty;

    assign full  = (count == DEPTH_C);
    assign empty = (count == '0);
    assign rdata = mem[rd_ptr];

    // Storage array carries no reset; only the pointers define what is valid.
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= wdata;
        end
    end

    // Pointers wrap naturally because DEPTH is a power of two. A push and a
    // pop in the same cycle move both pointers and leave the count alone.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/tt_uio_uart_tx.sv
// tt_uio_uart_tx
//   Buffers bytes from the core and serialises them as 8N1 UART frames on
//   one uio pin, driving that pin's output enable.
//   Parameters:
//     DIV         clock cycles per UART bit (>= 2)
//     FIFO_DEPTH  buffered bytes besides the one being shifted (power of two)
//   Ports:
//     clk       in   system clock
//     rst_n     in   asynchronous active-low reset
//     ena       in   design enable; low stops new frames from starting
//     in_data   in   byte to transmit
//     in_valid  in   in_data valid
//     in_ready  out  FIFO has room; byte moves on in_valid && in_ready
//     tx        out  registered serial line, idle high
//     tx_oe     out  registered output enable, high from first edge after reset
//     busy      out  frame in progress or bytes waiting
module tt_uio_uart_tx
    import tt_uart_pkg::*;
#(
    parameter int DIV        = 434,
    parameter int FIFO_DEPTH = 4
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       ena,
    input  logic [7:0] in_data,
    input  logic       in_valid,
    output logic       in_ready,
    output logic       tx,
    output logic       tx_oe,
    output logic       busy
);

    localparam int CW = (DIV > 1) ? $clog2(DIV) : 1;
    localparam logic [CW-1:0] BAUD_LAST = CW'(DIV - 1);
    localparam logic [2:0]    BIT_LAST  = 3'(UART_DATA_BITS - 1);

    tx_state_t  state;
    logic [CW-1:0] baud_cnt;
    logic [2:0] bit_idx;
    logic [7:0] shift;

    logic       fifo_full;
    logic       fifo_empty;
    logic       fifo_push;
    logic       fifo_pop;
    logic [7:0] fifo_rdata;
    logic       baud_done;
    logic       can_start;

    tt_sync_fifo #(
        .WIDTH (8),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst_n (rst_n),
        .push  (fifo_push),
        .wdata (in_data),
        .pop   (fifo_pop),
        .rdata (fifo_rdata),
        .full  (fifo_full),
        .empty (fifo_empty)
    );

    assign in_ready  = !fifo_full;
    assign fifo_push = in_valid && !fifo_full;
    assign baud_done = (baud_cnt == BAUD_LAST);
    assign can_start = !fifo_empty && ena;

    // A new byte is taken either from idle or straight out of a finished
    // stop bit, which is what makes back-to-back frames gapless.
    assign fifo_pop = can_start && ((state == IDLE) || ((state == STOP) && baud_done));

    assign busy = (state != IDLE) || !fifo_empty;

    // Output enable turns on at the first edge after reset and stays on.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tx_oe <= 1'b0;
        end else begin
            tx_oe <= 1'b1;
        end
    end

    // Frame sequencer. tx is registered and always updated together with the
    // state change so the line level for a bit appears on the same edge the
    // bit period starts; the baud counter restarts at every bit boundary.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            baud_cnt <= '0;
            bit_idx  <= '0;
            shift    <= '0;
            tx       <= 1'b1;
        end else begin
            case (state)
                IDLE: begin
                    baud_cnt <= '0;
                    if (fifo_pop) begin
                        state <= START;
                        shift <= fifo_rdata;
                        tx    <= 1'b0;
                    end
                end
                START: begin
                    if (baud_done) begin
                        state    <= DATA;
                        baud_cnt <= '0;
                        bit_idx  <= '0;
                        tx       <= shift[0];
                    end else begin
                        baud_cnt <= baud_cnt + 1'b1;
                    end
                end
                DATA: begin
                    if (baud_done) begin
                        baud_cnt <= '0;
                        if (bit_idx == BIT_LAST) begin
                            state <= STOP;
                            tx    <= 1'b1;
                        end else begin
                            bit_idx <= bit_idx + 1'b1;
                            shift   <= {1'b0, shift[7:1]};
                            tx      <= shift[1];
                        end
                    end else begin
                        baud_cnt <= baud_cnt + 1'b1;
                    end
                end
                STOP: begin
                    if (baud_done) begin
                        baud_cnt <= '0;
                        if (fifo_pop) begin
                            state <= START;
                            shift <= fifo_rdata;
                            tx    <= 1'b0;
                        end else begin
                            state <= IDLE;
                        end
                    end else begin
                        baud_cnt <= baud_cnt + 1'b1;
                    end
                end
                default: begin
                    state    <= IDLE;
                    baud_cnt <= '0;
                    tx       <= 1'b1;
                end
            endcase
        end
    end

endmodule
